// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
// Module      : time_counter
// Description : 24-hour BCD time-of-day counter (hh:mm:ss) advanced by a
//               one-cycle 1 Hz enable, with pause and validated direct load.
//               The hour field feeds the downstream date stage.
// Revision    : 1.0 - initial release
// ============================================================================
module time_counter #(
  parameter logic [7:0] HOUR_MAX = 8'h23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [23:0] time_in,
  input  logic [1:0]  time_mode,
  output logic [23:0] time_out,
  output logic [7:0]  hour_out,
  output logic        sec_pulse,
  output logic        day_wrap,
  output logic        load_err
);

  localparam logic [1:0] C_MODE_RUN   = 2'b00;
  localparam logic [1:0] C_MODE_PAUSE = 2'b01;
  localparam logic [1:0] C_MODE_LOAD  = 2'b10;
  localparam logic [1:0] C_MODE_RUN_D = 2'b11;

  logic [23:0] r_time;
  logic        r_sec_pulse;
  logic        r_day_wrap;
  logic        r_load_err;

  logic [7:0]  w_hh;
  logic [7:0]  w_mm;
  logic [7:0]  w_ss;
  logic        w_ss_wrap;
  logic        w_mm_wrap;
  logic        w_day_end;
  logic [23:0] w_time_next;
  logic        w_load_valid;

  // Increment a BCD byte by one; low nibble 9 carries into the high nibble.
  // Callers handle the field-specific wrap points.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      bcd_inc = {v[7:4] + 4'd1, 4'd0};
    end else begin
      bcd_inc = {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  // A byte is a legal minute/second value when it lies in 00..59.
  function automatic logic bcd_le59(input logic [7:0] v);
    bcd_le59 = (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  assign w_hh = r_time[23:16];
  assign w_mm = r_time[15:8];
  assign w_ss = r_time[7:0];

  // Next time value one second ahead, rippling carries from ss to hh.
  always_comb begin
    w_ss_wrap   = (w_ss == 8'h59);
    w_mm_wrap   = (w_mm == 8'h59);
    w_day_end   = w_ss_wrap && w_mm_wrap && (w_hh == HOUR_MAX);
    w_time_next = r_time;
    w_time_next[7:0] = w_ss_wrap ? 8'h00 : bcd_inc(w_ss);
    if (w_ss_wrap) begin
      w_time_next[15:8] = w_mm_wrap ? 8'h00 : bcd_inc(w_mm);
      if (w_mm_wrap) begin
        w_time_next[23:16] = (w_hh == HOUR_MAX) ? 8'h00 : bcd_inc(w_hh);
      end
    end
  end

  // Load value check: every nibble decimal, hh <= HOUR_MAX, mm/ss <= 59.
  always_comb begin
    w_load_valid = (time_in[23:20] <= 4'd9) && (time_in[19:16] <= 4'd9)
                && (time_in[23:16] <= HOUR_MAX)
                && bcd_le59(time_in[15:8]) && bcd_le59(time_in[7:0]);
  end

  // Time register and status pulses; load beats tick, pause freezes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_time      <= 24'h000000;
      r_sec_pulse <= 1'b0;
      r_day_wrap  <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_sec_pulse <= 1'b0;
      r_day_wrap  <= 1'b0;
      r_load_err  <= 1'b0;
      case (time_mode)
        C_MODE_LOAD: begin
          if (w_load_valid) begin
            r_time <= time_in;
          end else begin
            r_load_err <= 1'b1;
          end
        end
        C_MODE_PAUSE: begin
          r_time <= r_time;
        end
        C_MODE_RUN, C_MODE_RUN_D: begin
          if (tick) begin
            r_time      <= w_time_next;
            r_sec_pulse <= 1'b1;
            r_day_wrap  <= w_day_end;
          end
        end
        default: begin
          r_time <= r_time;
        end
      endcase
    end
  end

  assign time_out  = r_time;
  assign hour_out  = r_time[23:16];
  assign sec_pulse = r_sec_pulse;
  assign day_wrap  = r_day_wrap;
  assign load_err  = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_counter
// Description : Directed self-checking bench for time_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_counter;

  logic        clk;
  logic        rst;
  logic        tick;
  logic [23:0] time_in;
  logic [1:0]  time_mode;
  logic [23:0] time_out;
  logic [7:0]  hour_out;
  logic        sec_pulse;
  logic        day_wrap;
  logic        load_err;

  int vectors;
  int miscompares;
  int pulse_cnt;
  int wrap_cnt;

  time_counter dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .time_in   (time_in),
    .time_mode (time_mode),
    .time_out  (time_out),
    .hour_out  (hour_out),
    .sec_pulse (sec_pulse),
    .day_wrap  (day_wrap),
    .load_err  (load_err)
  );

  // 10 ns master clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one edge, then sample 1 ns after it.
  task automatic cyc(input logic t, input logic [1:0] m, input logic [23:0] d);
    tick      = t;
    time_mode = m;
    time_in   = d;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    logic [23:0] carry_ld  [3];
    logic [23:0] carry_exp [3];
    logic [23:0] bad_ld    [3];
    carry_ld  = '{24'h095959, 24'h195959, 24'h000009};
    carry_exp = '{24'h100000, 24'h200000, 24'h000010};
    bad_ld    = '{24'h245900, 24'h12A000, 24'h126000};

    vectors = 0; miscompares = 0;
    rst = 1'b1; tick = 1'b0; time_mode = 2'b00; time_in = 24'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_time", time_out, 24'h000000);
    chk("reset_hour", hour_out, 8'h00);
    chk("reset_flags", {sec_pulse, day_wrap, load_err}, 3'b000);
    rst = 1'b0;

    // 65 ticks in run mode (tick effectively held high).
    pulse_cnt = 0; wrap_cnt = 0;
    for (int i = 0; i < 65; i++) begin
      cyc(1'b1, 2'b00, 24'h0);
      pulse_cnt += int'(sec_pulse);
      wrap_cnt  += int'(day_wrap);
    end
    chk("run65_time", time_out, 24'h000105);
    chk("run65_pulses", pulse_cnt, 65);
    chk("run65_wraps", wrap_cnt, 0);
    cyc(1'b0, 2'b00, 24'h0);
    chk("idle_pulse", sec_pulse, 1'b0);
    chk("idle_time", time_out, 24'h000105);

    // Day wrap.
    cyc(1'b0, 2'b10, 24'h235958);
    chk("load_235958", time_out, 24'h235958);
    cyc(1'b1, 2'b00, 24'h0);
    chk("tick_235959", time_out, 24'h235959);
    chk("pre_wrap_flag", day_wrap, 1'b0);
    chk("pre_wrap_hour", hour_out, 8'h23);
    cyc(1'b1, 2'b00, 24'h0);
    chk("wrap_time", time_out, 24'h000000);
    chk("wrap_flag", day_wrap, 1'b1);
    chk("wrap_hour", hour_out, 8'h00);
    chk("wrap_pulse", sec_pulse, 1'b1);
    cyc(1'b0, 2'b00, 24'h0);
    chk("wrap_one_clk", day_wrap, 1'b0);

    // BCD carries.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'b10, carry_ld[i]);
      cyc(1'b1, 2'b00, 24'h0);
      chk("bcd_carry", time_out, carry_exp[i]);
    end

    // Invalid loads.
    cyc(1'b0, 2'b10, 24'h123456);
    chk("load_123456", time_out, 24'h123456);
    chk("valid_no_err", load_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'b10, bad_ld[i]);
      chk("bad_err", load_err, 1'b1);
      chk("bad_hold", time_out, 24'h123456);
    end
    cyc(1'b0, 2'b10, 24'h080000);
    chk("good_after_bad", time_out, 24'h080000);
    chk("err_cleared", load_err, 1'b0);
    cyc(1'b0, 2'b10, 24'h245900);
    chk("bad_again", load_err, 1'b1);
    cyc(1'b0, 2'b01, 24'h245900);
    chk("err_clr_mode", load_err, 1'b0);

    // Pause ignores ticks.
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 2'b01, 24'h0);
      pulse_cnt += int'(sec_pulse) + int'(day_wrap);
    end
    chk("pause_time", time_out, 24'h080000);
    chk("pause_pulses", pulse_cnt, 0);

    // Load has priority over tick; counting resumes from the load.
    cyc(1'b1, 2'b10, 24'h010203);
    chk("load_tick_time", time_out, 24'h010203);
    chk("load_tick_pulse", sec_pulse, 1'b0);
    cyc(1'b1, 2'b00, 24'h0);
    chk("resume_time", time_out, 24'h010204);
    cyc(1'b1, 2'b11, 24'h0);
    chk("mode11_time", time_out, 24'h010205);

    // Loading 000000 never flags a day wrap.
    cyc(1'b0, 2'b10, 24'h000000);
    chk("load0_wrap", day_wrap, 1'b0);

    // Async reset mid-cycle at 23:59:59 with a tick pending.
    cyc(1'b0, 2'b10, 24'h235959);
    tick = 1'b1; time_mode = 2'b00;
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_time", time_out, 24'h000000);
    chk("async_rst_wrap", day_wrap, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b1, 2'b00, 24'h0);
    chk("post_rst_tick", time_out, 24'h000001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/time_counter.md
Name: time_counter

Overview:
- 24-hour BCD time-of-day counter (hh:mm:ss), advanced by a one-cycle 1 Hz enable.
- Sits directly upstream of the date stage; its hour field drives that stage's hour input.
- The date stage detects the day boundary itself, from the hour going 23 -> 00.
- Supports pause and direct time load under mode control, and validates loaded values.

Parameters:
- HOUR_MAX, 8'h23: BCD value of the last hour before wrap; fixed 24 h format, not intended to be overridden.

Ports:
- clk  input  1  master clock (mclk); all state updates on its rising edge
- rst  input  1  reset, asynchronous and active-high
- tick  input  1  one-clk-wide 1 Hz advance enable
- time_in  input  24  load value {hh, mm, ss}, each field 8-bit BCD
- time_mode  input  2  00 run, 01 pause, 10 load time, 11 run (date set in progress; time keeps counting)
- time_out  output  24  current {hh, mm, ss} BCD, registered
- hour_out  output  8  equals time_out[23:16]; feeds the date stage
- sec_pulse  output  1  one-clk pulse each time seconds advance
- day_wrap  output  1  one-clk pulse on the 23:59:59 -> 00:00:00 transition
- load_err  output  1  high while time_mode=10 and time_in is invalid

Behaviour:
- Reset (async, active-high):
  - time_out = 24'h000000, hour_out = 8'h00
  - sec_pulse = 0, day_wrap = 0, load_err = 0
  - Counting resumes on the first tick after rst deasserts.
- All outputs are registered; zero combinational paths from inputs to outputs.
- Run (mode 00 or 11), tick=1 at an edge: the value advances by one second at that same edge.
- Per-field BCD rules; increment is on the low nibble, with carry into the high nibble when the low nibble is 9:
  - ss:
    - x9 -> (x+1)0
    - 59 -> 00, with carry into mm.
  - mm:
    - Same rules as ss.
    - Increments only on a carry from ss.
  - hh:
    - 09 -> 10, 19 -> 20.
    - 23 -> 00 on a carry from mm.
- Counter state: the value only ever steps through legal BCD values; the nibbles A-F never appear.
- sec_pulse: asserted for one clk at the edge where a tick is accepted, i.e. coincident with the new time_out value.
- day_wrap: asserted for one clk at the edge where time_out becomes 000000 via counting.
  - A load of 000000 never asserts day_wrap.
- Pause (mode 01):
  - Ticks are ignored; time_out holds.
  - sec_pulse and day_wrap stay 0.
- Load (mode 10):
  - Level-sensitive: every edge with a valid time_in copies it to time_out.
  - Ticks are ignored; sec_pulse and day_wrap stay 0.
  - Valid means every nibble is 0-9, hh <= 23, mm <= 59, ss <= 59.
  - Invalid time_in: time_out holds its previous value and load_err = 1, registered at the edge.
  - load_err clears on the first edge where time_in is valid or the mode is not 10.
- Leaving load mode: counting resumes from the loaded value on the next accepted tick. No extra delay and no lost state.
- Simultaneous events:
  - A tick in the same cycle as a mode change is governed by the mode sampled at that edge.
  - Load has priority over tick.
- Reset mid-operation: asserting rst at any point, including during load or at 23:59:59, forces the reset values immediately (asynchronously). Pending pulses are dropped.
- Downstream timing: hour_out goes 23 -> 00 coincident with day_wrap. The date stage registers its own day edge one clk later; this block adds no extra delay.
- tick held high for multiple clks: each clk with tick=1 counts as one advance. The block does not edge-detect tick; the tick source guarantees a single-cycle pulse.

Test Plan:
- Reset, then 65 ticks in mode 00 -> time_out = 000105; sec_pulse asserted 65 times; day_wrap never asserted.
- Load 235958 (mode 10), then mode 00 and 2 ticks:
  - 1st tick -> 235959
  - 2nd tick -> 000000, with day_wrap = 1 for exactly one clk and hour_out 23 -> 00
- BCD carry checks:
  - Load 095959, 1 tick -> 100000.
  - Load 195959, 1 tick -> 200000.
  - Load 000009, 1 tick -> 000010.
- Invalid loads, starting from time_out = 123456:
  - 245900 -> load_err = 1, time_out stays 123456.
  - 12A000 and 126000 -> same response.
  - A valid 080000 then loads on the next edge and load_err drops.
- Mode 01 with 10 ticks -> time_out unchanged, no pulses. Mode 10 with a tick in the same cycle as a valid load of 010203 -> 010203, tick ignored.
- rst asserted asynchronously (mid-cycle) at 235959 with a tick pending -> time_out = 000000 before the next clk edge, day_wrap = 0, and the first post-reset tick gives 000001.
